// File: rtl/noc_pkg.sv
// Shared router-tile definitions: port indices, arbiter FSM states, one-hot helper.
// Pure declarations; no logic, no latency, no backpressure.
package noc_pkg;

  localparam int PORT_L = 3;
  localparam int PORT_W = 2;
  localparam int PORT_N = 1;
  localparam int PORT_S = 0;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_arb4_ch.sv
// One output channel: round-robin over 4 inputs, holds grant while full, locks head-to-tail.
// arb_res is combinational (zero latency); a full stall freezes the grant until transfer.
module rr_arb4_ch
  import noc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] tail_in,
  input  logic       full,
  output logic [3:0] arb_res,
  output logic       locked
);

  arb_state_e state;
  logic [1:0] ptr;
  logic [1:0] owner;
  logic       pkt;

  logic [1:0] win;
  logic       win_vld;
  logic [1:0] idx;
  logic [1:0] cand;
  logic       cand_vld;

  // Walk from lowest to highest priority so the last hit (ptr itself) wins.
  always_comb begin
    win     = 2'd0;
    win_vld = 1'b0;
    idx     = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr - 2'(k);
      if (req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    cand     = win;
    cand_vld = win_vld;
    if (state == HOLD) begin
      cand     = owner;
      cand_vld = req[owner];
    end
  end

  assign arb_res = (cand_vld && rst_n) ? onehot4(cand) : 4'b0000;
  assign locked  = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 2'd3;
      owner <= 2'd0;
      pkt   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cand_vld) begin
            owner <= cand;
            if (!full) begin
              ptr <= cand - 2'd1;
              if (!tail_in[cand]) begin
                pkt   <= 1'b1;
                state <= HOLD;
              end
            end else begin
              // Stalled head: pin the grant so it is stable next cycle.
              pkt   <= 1'b0;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (cand_vld) begin
            if (!full) begin
              ptr <= owner - 2'd1;
              if (tail_in[owner]) begin
                pkt   <= 1'b0;
                state <= IDLE;
              end else begin
                pkt <= 1'b1;
              end
            end
          end else if (!pkt) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/switch_arbiter12.sv
// Per-output round-robin arbiter bank for the L/W/N/S router tile.
// Zero-latency grants; each channel stalls on its own downstream full (L never full).
module switch_arbiter12
  import noc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_L,
  input  logic [3:0] req_W,
  input  logic [3:0] req_N,
  input  logic [3:0] req_S,
  input  logic [3:0] tail_in,
  input  logic       N_full,
  input  logic       S_full,
  input  logic       W_full,
  output logic [3:0] L_arb_res,
  output logic [3:0] W_arb_res,
  output logic [3:0] N_arb_res,
  output logic [3:0] S_arb_res,
  output logic       L_locked,
  output logic       W_locked,
  output logic       N_locked,
  output logic       S_locked
);

  rr_arb4_ch u_ch_l (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_L),
    .tail_in (tail_in),
    .full    (1'b0),
    .arb_res (L_arb_res),
    .locked  (L_locked)
  );

  rr_arb4_ch u_ch_w (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_W),
    .tail_in (tail_in),
    .full    (W_full),
    .arb_res (W_arb_res),
    .locked  (W_locked)
  );

  rr_arb4_ch u_ch_n (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_N),
    .tail_in (tail_in),
    .full    (N_full),
    .arb_res (N_arb_res),
    .locked  (N_locked)
  );

  rr_arb4_ch u_ch_s (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_S),
    .tail_in (tail_in),
    .full    (S_full),
    .arb_res (S_arb_res),
    .locked  (S_locked)
  );

endmodule

// File: tb/tb_switch_arbiter12.sv
// Bench for switch_arbiter12: directed scenarios plus randomized traffic against a reference model.
module tb_switch_arbiter12;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_a [4];
  logic [3:0] tail_in;
  logic       full_n, full_s, full_w;
  logic [3:0] res_l, res_w, res_n, res_s;
  logic       lk_l, lk_w, lk_n, lk_s;

  int total = 0;
  int bad   = 0;

  // Reference model state, channel index = output port index (3=L..0=S).
  int m_ptr   [4];
  int m_owner [4];
  bit m_pkt   [4];
  bit m_hold  [4];

  switch_arbiter12 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_L     (req_a[3]),
    .req_W     (req_a[2]),
    .req_N     (req_a[1]),
    .req_S     (req_a[0]),
    .tail_in   (tail_in),
    .N_full    (full_n),
    .S_full    (full_s),
    .W_full    (full_w),
    .L_arb_res (res_l),
    .W_arb_res (res_w),
    .N_arb_res (res_n),
    .S_arb_res (res_s),
    .L_locked  (lk_l),
    .W_locked  (lk_w),
    .N_locked  (lk_n),
    .S_locked  (lk_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] get_res(input int ch);
    case (ch)
      3: get_res = res_l;
      2: get_res = res_w;
      1: get_res = res_n;
      default: get_res = res_s;
    endcase
  endfunction

  function automatic logic get_lk(input int ch);
    case (ch)
      3: get_lk = lk_l;
      2: get_lk = lk_w;
      1: get_lk = lk_n;
      default: get_lk = lk_s;
    endcase
  endfunction

  function automatic bit eff_full(input int ch);
    case (ch)
      2: eff_full = full_w;
      1: eff_full = full_n;
      0: eff_full = full_s;
      default: eff_full = 1'b0;
    endcase
  endfunction

  // First requester scanning ptr, ptr-1, ... (mod 4); -1 if none.
  function automatic int pick(input int p, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (p - k + 4) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_res(input int ch);
    int w;
    logic [3:0] r;
    r = req_a[ch];
    if (!m_hold[ch]) begin
      w = pick(m_ptr[ch], r);
      return (w < 0) ? 4'b0000 : 4'(1 << w);
    end
    return r[m_owner[ch]] ? 4'(1 << m_owner[ch]) : 4'b0000;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_ptr[c] = 3; m_owner[c] = 0; m_pkt[c] = 0; m_hold[c] = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < 4; c++) begin
      int w;
      bit f;
      f = eff_full(c);
      if (!m_hold[c]) begin
        w = pick(m_ptr[c], req_a[c]);
        if (w >= 0) begin
          m_owner[c] = w;
          if (!f) begin
            m_ptr[c] = (w + 3) % 4;
            if (!tail_in[w]) begin m_pkt[c] = 1; m_hold[c] = 1; end
          end else begin
            m_pkt[c] = 0; m_hold[c] = 1;
          end
        end
      end else begin
        w = m_owner[c];
        if (req_a[c][w]) begin
          if (!f) begin
            m_ptr[c] = (w + 3) % 4;
            if (tail_in[w]) begin m_pkt[c] = 0; m_hold[c] = 0; end
            else m_pkt[c] = 1;
          end
        end else if (!m_pkt[c]) begin
          m_hold[c] = 0;
        end
      end
    end
  endtask

  task automatic clear_inputs();
    for (int c = 0; c < 4; c++) req_a[c] = 4'b0000;
    tail_in = 4'b1111;
    full_n = 0; full_s = 0; full_w = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // End of a checked cycle: advance model with the inputs the DUT samples.
  task automatic tick();
    model_step();
    @(posedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) req_a[c] = 4'b1111;
    @(negedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (get_res(c) !== 4'b0000) begin
        bad++; $display("FAIL reset_res ch%0d got=%b want=0000", c, get_res(c));
      end
      total++;
      if (get_lk(c) !== 1'b0) begin
        bad++; $display("FAIL reset_locked ch%0d got=%b want=0", c, get_lk(c));
      end
    end
    do_reset();
  endtask

  task automatic test_fairness();
    logic [3:0] seq [4];
    seq[0] = 4'b1000; seq[1] = 4'b0100; seq[2] = 4'b0010; seq[3] = 4'b0001;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_a[0] = 4'b1111; tail_in = 4'b1111; full_s = 0;
      #1;
      total++;
      if (res_s !== seq[i % 4]) begin
        bad++; $display("FAIL fairness cyc%0d got=%b want=%b", i, res_s, seq[i % 4]);
      end
      tick();
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_a[1] = 4'b0110; full_n = (i < 3);
      #1;
      total++;
      if (res_n !== 4'b0100) begin
        bad++; $display("FAIL stall_hold cyc%0d got=%b want=0100", i, res_n);
      end
      if (i > 0) begin
        total++;
        if (lk_n !== 1'b1) begin
          bad++; $display("FAIL stall_locked cyc%0d got=%b want=1", i, lk_n);
        end
      end
      tick();
    end
    @(negedge clk);
    req_a[1] = 4'b0110; full_n = 0;
    #1;
    total++;
    if (res_n !== 4'b0010) begin
      bad++; $display("FAIL stall_next got=%b want=0010", res_n);
    end
    tick();
  endtask

  task automatic test_packet_lock();
    logic lk_exp [4];
    lk_exp[0] = 0; lk_exp[1] = 1; lk_exp[2] = 1; lk_exp[3] = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_a[3] = 4'b0101;
      tail_in  = (i < 2) ? 4'b1011 : 4'b1111;
      #1;
      total++;
      if (lk_l !== lk_exp[i]) begin
        bad++; $display("FAIL lock_state cyc%0d got=%b want=%b", i, lk_l, lk_exp[i]);
      end
      total++;
      if (res_l !== ((i < 3) ? 4'b0100 : 4'b0001)) begin
        bad++; $display("FAIL lock_grant cyc%0d got=%b want=%b", i, res_l,
                        (i < 3) ? 4'b0100 : 4'b0001);
      end
      tick();
    end
  endtask

  task automatic test_body_bubble();
    logic [3:0] rq  [4];
    logic [3:0] tl  [4];
    logic [3:0] ex  [4];
    logic       lke [4];
    rq[0] = 4'b1001; tl[0] = 4'b0111; ex[0] = 4'b1000; lke[0] = 0;
    rq[1] = 4'b0001; tl[1] = 4'b0111; ex[1] = 4'b0000; lke[1] = 1;
    rq[2] = 4'b1001; tl[2] = 4'b1111; ex[2] = 4'b1000; lke[2] = 1;
    rq[3] = 4'b1001; tl[3] = 4'b1111; ex[3] = 4'b0001; lke[3] = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_a[2] = rq[i]; tail_in = tl[i]; full_w = 0;
      #1;
      total++;
      if (res_w !== ex[i]) begin
        bad++; $display("FAIL bubble_grant cyc%0d got=%b want=%b", i, res_w, ex[i]);
      end
      total++;
      if (lk_w !== lke[i]) begin
        bad++; $display("FAIL bubble_locked cyc%0d got=%b want=%b", i, lk_w, lke[i]);
      end
      tick();
    end
  endtask

  task automatic test_abandoned_stall();
    do_reset();
    @(negedge clk);
    req_a[0] = 4'b0001; full_s = 1;
    #1;
    total++;
    if (res_s !== 4'b0001) begin
      bad++; $display("FAIL abandon_grant got=%b want=0001", res_s);
    end
    tick();
    @(negedge clk);
    req_a[0] = 4'b0000;
    #1;
    total++;
    if (res_s !== 4'b0000 || lk_s !== 1'b1) begin
      bad++; $display("FAIL abandon_drop got=%b/%b want=0000/1", res_s, lk_s);
    end
    tick();
    @(negedge clk);
    req_a[0] = 4'b1111; full_s = 0;
    #1;
    total++;
    if (lk_s !== 1'b0 || res_s !== 4'b1000) begin
      bad++; $display("FAIL abandon_idle got=%b/%b want=1000/0", res_s, lk_s);
    end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    req_a[3] = 4'b1000; tail_in = 4'b0111;
    #1;
    tick();
    @(negedge clk);
    req_a[3] = 4'b1000;
    req_a[1] = 4'b0010;
    #1;
    total++;
    if (lk_l !== 1'b1) begin
      bad++; $display("FAIL areset_pre locked got=%b want=1", lk_l);
    end
    #1 rst_n = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (get_res(c) !== 4'b0000 || get_lk(c) !== 1'b0) begin
        bad++; $display("FAIL areset_now ch%0d got=%b/%b want=0000/0", c, get_res(c), get_lk(c));
      end
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    @(negedge clk);
    req_a[3] = 4'b1111;
    #1;
    total++;
    if (res_l !== 4'b1000) begin
      bad++; $display("FAIL areset_ptr got=%b want=1000", res_l);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) req_a[c] = 4'($urandom_range(0, 15));
      tail_in = 4'($urandom_range(0, 15));
      full_n = ($urandom_range(0, 3) == 0);
      full_s = ($urandom_range(0, 3) == 0);
      full_w = ($urandom_range(0, 3) == 0);
      #1;
      for (int c = 0; c < 4; c++) begin
        total++;
        if (get_res(c) !== model_res(c)) begin
          bad++; $display("FAIL rand_res cyc%0d ch%0d got=%b want=%b", i, c, get_res(c), model_res(c));
        end
        total++;
        if (get_lk(c) !== m_hold[c]) begin
          bad++; $display("FAIL rand_locked cyc%0d ch%0d got=%b want=%b", i, c, get_lk(c), m_hold[c]);
        end
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_fairness();
    test_stall_hold();
    test_packet_lock();
    test_body_bubble();
    test_abandoned_stall();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
